muldiv_iter: RTL and testbench

- Iterative multi-cycle multiply/divide unit for the EX stage; successor to the combinational mul/div path driven by the single-cycle ALU.
- Takes two operands plus sign/mode, runs a radix-2 shift-add multiply or restoring divide over DATA_WIDTH cycles, and returns a HI/LO pair with a one-cycle valid pulse.
- The pipeline stalls on !ready and commits hi_out/lo_out to HI/LO on res_valid.
- A cancel input aborts an in-flight operation on exception/flush.

---
 rtl/muldiv_iter.sv | 170 +++++++++++++++++
 tb/tb_muldiv_iter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// ============================================================================
// Module   : muldiv_iter
// Purpose  : Iterative radix-2 multiply / restoring divide returning HI/LO.
//            Define MULDIV_FAST_MUL_EN for a single-cycle registered multiply.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_div,
  input  logic                  sign,
  input  logic                  cancel,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  ready,
  output logic                  busy,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic                  div_zero
);

  localparam int W = DATA_WIDTH;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] c_CNT_INIT = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [W-1:0]         c_ONE_W    = W'(1);
  localparam logic [2*W-1:0]       c_ONE_2W   = (2*W)'(1);

  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_is_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [W-1:0]         r_opb;
  logic [2*W-1:0]       r_acc;
  logic [W-1:0]         r_hi;
  logic [W-1:0]         r_lo;
  logic                 r_dz;

  logic                 w_accept;
  logic [W-1:0]         w_mag_a;
  logic [W-1:0]         w_mag_b;
  logic                 w_neg_q_in;
  logic [W:0]           w_mul_sum;
  logic [2*W-1:0]       w_mul_nxt;
  logic [W:0]           w_shift;
  logic [W:0]           w_diff;
  logic [2*W-1:0]       w_div_nxt;
  logic [2*W-1:0]       w_step;
  logic [2*W-1:0]       w_prod_fix;
  logic [W-1:0]         w_quo_fix;
  logic [W-1:0]         w_rem_fix;
  logic [2*W-1:0]       w_final;

  assign w_accept   = (r_state != c_BUSY) && start && !cancel;
  assign w_mag_a    = (sign && src_a[W-1]) ? (~src_a + c_ONE_W) : src_a;
  assign w_mag_b    = (sign && src_b[W-1]) ? (~src_b + c_ONE_W) : src_b;
  assign w_neg_q_in = sign && (src_a[W-1] ^ src_b[W-1]);

  // Multiply: upper half accumulates, lower half holds the shrinking multiplier.
  assign w_mul_sum = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_opb};
  assign w_mul_nxt = r_acc[0] ? {w_mul_sum, r_acc[W-1:1]}
                              : {1'b0, r_acc[2*W-1:1]};

  // Divide: upper half is the partial remainder, lower half dividend -> quotient.
  // The remainder stays below the divisor, so w_diff[W] is a reliable sign.
  assign w_shift   = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_diff    = w_shift - {1'b0, r_opb};
  assign w_div_nxt = w_diff[W] ? {w_shift[W-1:0], r_acc[W-2:0], 1'b0}
                               : {w_diff[W-1:0], r_acc[W-2:0], 1'b1};

  assign w_step = r_is_div ? w_div_nxt : w_mul_nxt;

  assign w_prod_fix = r_neg_q ? (~w_step + c_ONE_2W) : w_step;
  assign w_quo_fix  = r_neg_q ? (~w_step[W-1:0] + c_ONE_W) : w_step[W-1:0];
  assign w_rem_fix  = r_neg_r ? (~w_step[2*W-1:W] + c_ONE_W) : w_step[2*W-1:W];
  assign w_final    = r_is_div ? {w_rem_fix, w_quo_fix} : w_prod_fix;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] w_fast_prod;
  logic [2*W-1:0] w_fast_fix;

  assign w_fast_prod = {{W{1'b0}}, w_mag_a} * {{W{1'b0}}, w_mag_b};
  assign w_fast_fix  = w_neg_q_in ? (~w_fast_prod + c_ONE_2W) : w_fast_prod;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        c_BUSY: begin
          if (cancel) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt - c_CNT_ONE;
            if (r_cnt == c_CNT_ONE) begin
              r_state <= c_DONE;
              r_hi    <= w_final[2*W-1:W];
              r_lo    <= w_final[W-1:0];
              r_dz    <= 1'b0;
            end
          end
        end
        default: begin
          if (w_accept) begin
            r_is_div <= is_div;
            r_neg_q  <= w_neg_q_in;
            r_neg_r  <= sign && src_a[W-1];
            if (is_div && (src_b == '0)) begin
              // Divide by zero skips iteration and reports the raw dividend.
              r_state <= c_DONE;
              r_hi    <= src_a;
              r_lo    <= '1;
              r_dz    <= 1'b1;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!is_div) begin
              r_state <= c_DONE;
              r_hi    <= w_fast_fix[2*W-1:W];
              r_lo    <= w_fast_fix[W-1:0];
              r_dz    <= 1'b0;
            end
`endif
            else begin
              r_state <= c_BUSY;
              r_cnt   <= c_CNT_INIT;
              r_opb   <= is_div ? w_mag_b : w_mag_a;
              r_acc   <= {{W{1'b0}}, (is_div ? w_mag_a : w_mag_b)};
            end
          end else begin
            r_state <= c_IDLE;
          end
        end
      endcase
    end
  end

  assign ready     = (r_state != c_BUSY);
  assign busy      = (r_state == c_BUSY);
  assign res_valid = (r_state == c_DONE) && !cancel;
  assign hi_out    = r_hi;
  assign lo_out    = r_lo;
  assign div_zero  = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_iter.sv
// ============================================================================
// Module   : tb_muldiv_iter
// Purpose  : Scoreboard bench for muldiv_iter (directed vectors, latency check).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_iter;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_div;
  logic         sign;
  logic         cancel;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         ready;
  logic         busy;
  logic         res_valid;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;
  logic         div_zero;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  muldiv_iter #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_div    (is_div),
    .sign      (sign),
    .cancel    (cancel),
    .src_a     (src_a),
    .src_b     (src_b),
    .ready     (ready),
    .busy      (busy),
    .res_valid (res_valid),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per result pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_res_valid hi=%h lo=%h", hi_out, lo_out);
        end else begin
          e = q.pop_front();
          chk({e.name, "_hi"}, hi_out, e.hi);
          chk({e.name, "_lo"}, lo_out, e.lo);
          chk({e.name, "_dz"}, div_zero, e.dz);
          chk({e.name, "_lat"}, cyc - e.acc_cyc + 1, e.lat);
        end
      end
    end
  end

  task automatic issue(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic dv, input logic sg, input logic [W-1:0] ehi,
                       input logic [W-1:0] elo, input logic edz, input int elat);
    exp_t e;
    int   n;
    @(posedge clk); #2;
    src_a = a; src_b = b; is_div = dv; sign = sg; start = 1'b1;
    @(posedge clk); #1;
    e.name = nm; e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = elat; e.acc_cyc = cyc;
    q.push_back(e);
    #1 start = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_result expected=res_valid", nm);
      q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; is_div = 1'b0; sign = 1'b0; cancel = 1'b0;
    src_a = '0; src_b = '0;
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_hi", hi_out, '0);
    chk("rst_lo", lo_out, '0);
    chk("rst_dz", div_zero, 1'b0);
    #11 rst = 1'b0;

    issue("umul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b0, MUL_LAT);
    issue("sdiv_m7_2", 32'hFFFFFFF9, 32'h00000002, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT);
    issue("smul_m3_5", 32'hFFFFFFFD, 32'h00000005, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, MUL_LAT);
    issue("div_zero", 32'h12345678, 32'h00000000, 1'b1, 1'b0, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1);
    issue("sdiv_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 32'h80000000, 1'b0, DIV_LAT);
    issue("udiv_min_max", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, 32'h00000000, 1'b0, DIV_LAT);
    issue("udiv_100_7", 32'd100, 32'd7, 1'b1, 1'b0, 32'd2, 32'd14, 1'b0, DIV_LAT);
    issue("sdiv_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, 32'd1, 32'hFFFFFFFD, 1'b0, DIV_LAT);
    issue("smul_m3_m5", 32'hFFFFFFFD, 32'hFFFFFFFB, 1'b0, 1'b1, 32'd0, 32'd15, 1'b0, MUL_LAT);

    // Cancel an in-flight divide; a start seen while busy must not take effect.
    @(posedge clk); #2;
    src_a = 32'd1000; src_b = 32'd3; is_div = 1'b1; sign = 1'b0; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    chk("busy_busy", busy, 1'b1);
    chk("busy_ready", ready, 1'b0);
    repeat (4) @(posedge clk);
    #2 start = 1'b1; src_a = 32'd5; src_b = 32'd0;
    @(posedge clk); #1;
    chk("start_in_busy_ignored", busy, 1'b1);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 cancel = 1'b1;
    @(posedge clk); #1;
    chk("cancel_busy", busy, 1'b0);
    chk("cancel_ready", ready, 1'b1);
    chk("cancel_hi_hold", hi_out, 32'd0);
    chk("cancel_lo_hold", lo_out, 32'd15);
    #1 cancel = 1'b0;
    repeat (40) @(posedge clk);

    // start together with cancel in IDLE is not accepted.
    #2 start = 1'b1; cancel = 1'b1; src_a = 32'd1000; src_b = 32'd3; is_div = 1'b1;
    @(posedge clk); #1;
    chk("start_cancel_busy", busy, 1'b0);
    #1 start = 1'b0; cancel = 1'b0;
    repeat (40) @(posedge clk);

    // Asynchronous reset in the middle of a divide.
    #2 start = 1'b1; src_a = 32'd1000; src_b = 32'd3; is_div = 1'b1; sign = 1'b0;
    @(posedge clk); #2 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_ready", ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_valid", res_valid, 1'b0);
    chk("arst_hi", hi_out, '0);
    chk("arst_lo", lo_out, '0);
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);

    issue("umul_6_7", 32'd6, 32'd7, 1'b0, 1'b0, 32'd0, 32'd42, 1'b0, MUL_LAT);
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
